complex_accum_n: RTL and testbench
==================================

COMPLEX_ACCUM_N -- requirements
Module: complex_accum_n

Interface
REQ-001 Parameter QI, default 3: integer bits of the signed input format; input components are signed [QI:-QF].
REQ-002 Parameter QF, default 3: fractional bits, shared by input and output.
REQ-003 Parameter N_TERMS, default 3: complex samples summed per result, range 2..16.
REQ-004 Parameter OUT_QI, default QI+1: integer bits of the output; output components are signed [OUT_QI:-QF].
REQ-005 Parameter SATURATE, default 0: 0 = two's-complement wrap on overflow, 1 = clamp to output max/min.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 clear  in  1  synchronous abort of the frame in progress.
REQ-009 in_valid  in  1  input sample present.
REQ-010 in_ready  out  1  block accepts a sample this cycle.
REQ-011 in_Re, in_Im  in  QI+QF+1 each  signed input sample.
REQ-012 out_valid  out  1  result held in output register.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_Re, out_Im  out  OUT_QI+QF+1 each  signed result.
REQ-015 overflow  out  1  result of this frame did not fit the output format (Re or Im).

Function
REQ-016 A beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-017 Internal Re/Im accumulators SHALL be QI+QF+1+clog2(N_TERMS) bits so no intermediate sum can overflow.
REQ-018 Term counter counts accepted beats 0..N_TERMS-1; the first beat of a frame loads the accumulator (no add to stale data).
REQ-019 States: IDLE (counter 0), ACCUM (0 < counter < N_TERMS), both with in_ready per REQ-022.
REQ-020 On the N_TERMS-th accepted beat, the full sum (including that beat) is converted per REQ-023/024 into out_Re/out_Im/overflow, out_valid goes 1 on the next cycle, counter returns to 0.
REQ-021 Latency: last input beat at edge k -> out_valid 1 after edge k; result is stable while out_valid=1 and out_ready=0.
REQ-022 in_ready = NOT (out_valid AND NOT out_ready); a result accepted and a new last beat on the same edge SHALL load the new result with out_valid staying 1.
REQ-023 Overflow per component: full sum outside [-2^(OUT_QI+QF), 2^(OUT_QI+QF)-1] raw; overflow = OR of Re and Im flags, valid with out_valid.
REQ-024 SATURATE=0: output = low OUT_QI+QF+1 bits of the sum; SATURATE=1: overflowed component clamped to raw max or min by sign; non-overflowed components unchanged.
REQ-025 out_valid clears on the edge where out_valid AND out_ready with no new result loaded; out_Re/out_Im/overflow hold their last values.
REQ-026 clear=1: counter and accumulators to 0 (partial frame discarded), out_valid and pending output untouched; clear has priority over a beat in the same cycle (beat dropped, in_ready still reported).

Reset
REQ-027 rst_n=0 asynchronously forces counter 0, accumulators 0, out_valid 0, out_Re 0, out_Im 0, overflow 0; state IDLE.
REQ-028 After rst_n deasserts, in_ready=1 from the first edge; reset mid-frame discards partial and pending results.

Verification (QI=3, QF=3, N_TERMS=3, OUT_QI=4; values are raw integers)
REQ-029 Beats (9,3),(1,6),(4,3), out_ready=1 -> one cycle after third beat out_valid=1, out=(14,12), overflow=0.
REQ-030 Beats (-3,-2),(1,1),(-1,-1) -> out=(-3,-2), overflow=0; then (0,0)x3 -> (0,0), overflow=0.
REQ-031 Beats (63,0)x3, SATURATE=0 -> out_Re=-67, out_Im=0, overflow=1; SATURATE=1 -> out_Re=127; (-64,-64)x3 -> wrap (64,64) / saturate (-128,-128), overflow=1.
REQ-032 out_ready=0 after result: in_ready=0, result held 5 cycles unchanged; out_ready=1 -> out_valid drops next edge, in_ready=1; back-to-back frames with out_ready=1 give one result every 3 accepted beats, no bubbles.
REQ-033 Two beats (5,5),(5,5), then clear, then (1,0),(2,0),(3,0) -> out=(6,0), partial frame absent.
REQ-034 rst_n pulsed low mid-frame and while out_valid=1 -> all outputs 0 immediately (no clock), next full frame sums correctly.

Source files
------------

// File: rtl/complex_accum_n.sv
// Complex sample accumulator: sums N_TERMS signed Re/Im beats per frame.
// Each result is converted to the output format with optional saturation.
module complex_accum_n #(
  parameter int QI       = 3,
  parameter int QF       = 3,
  parameter int N_TERMS  = 3,
  parameter int OUT_QI   = QI + 1,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [QI+QF:0]    in_Re,
  input  logic signed [QI+QF:0]    in_Im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_QI+QF:0] out_Re,
  output logic signed [OUT_QI+QF:0] out_Im,
  output logic                     overflow
);

  localparam int IW = QI + QF + 1;
  localparam int OW = OUT_QI + QF + 1;
  localparam int CW = $clog2(N_TERMS);
  localparam int AW = IW + CW;
  localparam int EW = (AW > OW) ? AW : OW;
  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic signed [AW-1:0] acc_re_q;
  logic signed [AW-1:0] acc_im_q;
  logic signed [AW-1:0] acc_re_d;
  logic signed [AW-1:0] acc_im_d;
  logic                 out_valid_q;
  logic [OW-1:0]        out_re_q;
  logic [OW-1:0]        out_im_q;
  logic                 ovf_q;

  logic                 beat;
  logic                 last;
  logic                 ovf_re;
  logic                 ovf_im;
  logic [OW-1:0]        res_re;
  logic [OW-1:0]        res_im;

  // Overflow when the bits above the output sign bit are not a pure sign run.
  function automatic logic [OW:0] conv(input logic signed [AW-1:0] s);
    logic signed [EW-1:0] e;
    logic [EW-OW:0]       top;
    logic                 o;
    logic [OW-1:0]        v;
    e   = EW'(s);
    top = e[EW-1:OW-1];
    o   = !((&top) || !(|top));
    v   = e[OW-1:0];
    if (SATURATE != 0 && o) begin
      v = e[EW-1] ? {1'b1, {(OW-1){1'b0}}}
                  : {1'b0, {(OW-1){1'b1}}};
    end
    return {o, v};
  endfunction

  assign in_ready = !(out_valid_q && !out_ready);
  assign beat     = in_valid && in_ready && !clear;
  assign last     = beat && (cnt_q == LAST);

  always_comb begin
    acc_re_d = AW'(in_Re);
    acc_im_d = AW'(in_Im);
    if (state_q == ACCUM) begin
      acc_re_d = acc_re_q + AW'(in_Re);
      acc_im_d = acc_im_q + AW'(in_Im);
    end
  end

  assign {ovf_re, res_re} = conv(acc_re_d);
  assign {ovf_im, res_im} = conv(acc_im_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (clear) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        acc_re_q <= '0;
        acc_im_q <= '0;
      end else if (beat) begin
        acc_re_q <= acc_re_d;
        acc_im_q <= acc_im_d;
        if (last) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= ACCUM;
          cnt_q   <= cnt_q + CW'(1);
        end
      end
      if (last) begin
        out_valid_q <= 1'b1;
        out_re_q    <= res_re;
        out_im_q    <= res_im;
        ovf_q       <= ovf_re || ovf_im;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_Re    = out_re_q;
  assign out_Im    = out_im_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_complex_accum_n.sv
// Bench for complex_accum_n: wrap and saturate instances side by side.
// Expected frames are queued at the last beat and popped on handshake.
module tb_complex_accum_n;

  typedef struct {
    int wre;
    int wim;
    int sre;
    int sim;
    int ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [6:0] in_Re = '0;
  logic signed [6:0] in_Im = '0;
  logic              out_ready = 1'b1;

  logic              in_ready0, in_ready1;
  logic              out_valid0, out_valid1;
  logic signed [7:0] re0, im0, re1, im1;
  logic              ov0, ov1;

  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;
  int   nres = 0;
  int   macc_re = 0;
  int   macc_im = 0;
  int   mn = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  complex_accum_n #(.SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_Re(in_Re), .in_Im(in_Im),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_Re(re0), .out_Im(im0), .overflow(ov0)
  );

  complex_accum_n #(.SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_Re(in_Re), .in_Im(in_Im),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_Re(re1), .out_Im(im1), .overflow(ov1)
  );

  task automatic check(string tag, logic signed [31:0] obs,
                       logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int wrap8(int x);
    return (((x + 128) % 256) + 256) % 256 - 128;
  endfunction

  function automatic int sat8(int x);
    return (x > 127) ? 127 : (x < -128) ? -128 : x;
  endfunction

  function automatic exp_t mk(int sr, int si);
    exp_t e;
    e.wre = wrap8(sr);
    e.wim = wrap8(si);
    e.sre = sat8(sr);
    e.sim = sat8(si);
    e.ovf = (sr > 127 || sr < -128 || si > 127 || si < -128) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid0 && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        nres++;
        check("wrap_re", 32'(re0), e.wre);
        check("wrap_im", 32'(im0), e.wim);
        check("wrap_ovf", 32'(ov0), e.ovf);
        check("sat_valid", 32'(out_valid1), 1);
        check("sat_re", 32'(re1), e.sre);
        check("sat_im", 32'(im1), e.sim);
        check("sat_ovf", 32'(ov1), e.ovf);
      end
    end
  end

  task automatic idle();
    in_valid = 1'b0;
    in_Re    = '0;
    in_Im    = '0;
  endtask

  task automatic beat(int re, int im);
    bit rdy;
    bit done;
    int g;
    g    = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_Re    = 7'(re);
    in_Im    = 7'(im);
    while (!done) begin
      @(negedge clk);
      rdy = in_ready0;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1'b1;
      end else begin
        g++;
        if (g > 50) begin
          check("beat_timeout", 1, 0);
          done = 1'b1;
          rdy  = 1'b0;
        end
      end
    end
    stalls += g;
    if (rdy) begin
      macc_re += re;
      macc_im += im;
      mn++;
      if (mn == 3) begin
        q.push_back(mk(macc_re, macc_im));
        macc_re = 0;
        macc_im = 0;
        mn      = 0;
      end
    end
  endtask

  task automatic clr(bit wb, int re, int im);
    clear    = 1'b1;
    in_valid = wb;
    in_Re    = 7'(re);
    in_Im    = 7'(im);
    @(negedge clk);
    check("clear_in_ready", 32'(in_ready0), 1);
    @(posedge clk);
    #1;
    clear   = 1'b0;
    idle();
    macc_re = 0;
    macc_im = 0;
    mn      = 0;
  endtask

  task automatic reset_pulse(string tag);
    rst_n = 1'b0;
    #2;
    check({tag, "_valid"}, 32'(out_valid0), 0);
    check({tag, "_re"}, 32'(re0), 0);
    check({tag, "_im"}, 32'(im0), 0);
    check({tag, "_ovf"}, 32'(ov0), 0);
    check({tag, "_sat_re"}, 32'(re1), 0);
    check({tag, "_ready"}, 32'(in_ready0), 1);
    #1;
    rst_n   = 1'b1;
    macc_re = 0;
    macc_im = 0;
    mn      = 0;
    q.delete();
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int r0;
    #2;
    check("rst_valid", 32'(out_valid0), 0);
    check("rst_re", 32'(re0), 0);
    check("rst_im", 32'(im0), 0);
    check("rst_ovf", 32'(ov0), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready0), 1);
    @(posedge clk);
    #1;

    beat(9, 3); beat(1, 6); beat(4, 3);
    idle();
    @(negedge clk);
    check("latency_valid", 32'(out_valid0), 1);
    drain();

    stalls = 0;
    r0     = nres;
    beat(-3, -2); beat(1, 1); beat(-1, -1);
    beat(0, 0); beat(0, 0); beat(0, 0);
    idle();
    drain();
    check("b2b_stalls", stalls, 0);
    check("b2b_results", nres - r0, 2);

    beat(63, 0); beat(63, 0); beat(63, 0);
    beat(-64, -64); beat(-64, -64); beat(-64, -64);
    idle();
    drain();

    out_ready = 1'b0;
    beat(2, -5); beat(7, 1); beat(3, 3);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid0), 1);
      check("hold_in_ready", 32'(in_ready0), 0);
      if (q.size() > 0) begin
        check("hold_re", 32'(re0), q[0].wre);
        check("hold_im", 32'(im0), q[0].wim);
      end else begin
        check("hold_queue", 0, 1);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("release_valid", 32'(out_valid0), 0);
    check("release_in_ready", 32'(in_ready0), 1);
    @(posedge clk);
    #1;

    beat(5, 5); beat(5, 5);
    idle();
    clr(1'b0, 0, 0);
    beat(1, 0); beat(2, 0); beat(3, 0);
    idle();
    drain();

    beat(1, 1);
    clr(1'b1, 50, 50);
    beat(1, 2); beat(3, 4); beat(5, 6);
    idle();
    drain();

    beat(10, 10); beat(10, 10);
    idle();
    reset_pulse("rst_mid");
    beat(1, 1); beat(1, 1); beat(1, 1);
    idle();
    drain();

    out_ready = 1'b0;
    beat(20, 20); beat(20, 20); beat(20, 20);
    idle();
    @(negedge clk);
    check("pend_valid", 32'(out_valid0), 1);
    @(posedge clk);
    #1;
    reset_pulse("rst_pend");
    out_ready = 1'b1;
    beat(-1, 2); beat(-1, 2); beat(-1, 2);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
